// File: rtl/bkg_scroll_reader.sv
// Background RAM scan engine: 4x4 pixel scaling, wrapping vertical scroll.
// Optional frame-paced scroll logic is built when BKG_SCROLL_EN is defined.
module bkg_scroll_reader #(
    parameter int IMG_DIM  = 160,
    parameter int SCALE_SH = 2,
    parameter int MAX_STEP = 31
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_tick,
    input  logic        scroll_add,
    input  logic [7:0]  scroll_amt,
    input  logic [23:0] data_In,
    output logic [14:0] read_address,
    output logic [23:0] bkg_rgb,
    output logic        bkg_valid,
    output logic [7:0]  scroll_offset
);

    localparam logic [9:0] VIS_W = 10'(IMG_DIM << SCALE_SH);
    localparam logic [9:0] VIS_H = 10'd480;
    localparam logic [8:0] DIM9  = 9'(IMG_DIM);

    logic        vis;
    logic [9:0]  col_full;
    logic [9:0]  yrow_full;
    logic [7:0]  col;
    logic [7:0]  yrow;
    logic [8:0]  y_sum;
    logic [8:0]  row9;
    logic [7:0]  row;
    logic [14:0] addr_c;
    logic        v1;
    logic        v2;

    assign vis       = (DrawX < VIS_W) && (DrawY < VIS_H);
    assign col_full  = DrawX >> SCALE_SH;
    assign yrow_full = DrawY >> SCALE_SH;
    assign col       = col_full[7:0];
    assign yrow      = yrow_full[7:0];

    // The sum never exceeds 2*IMG_DIM, so one subtract wraps it.
    assign y_sum = {1'b0, yrow} + {1'b0, scroll_offset};
    assign row9  = (y_sum >= DIM9) ? (y_sum - DIM9) : y_sum;
    assign row   = row9[7:0];

    assign addr_c = ({7'd0, row} << 7)
                  + ({7'd0, row} << 5)
                  + {7'd0, col};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{col_full[9:8], yrow_full[9:8], row9[8]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= 15'd0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            bkg_rgb      <= 24'd0;
            bkg_valid    <= 1'b0;
        end else begin
            if (vis)
                read_address <= addr_c;
            v1        <= vis;
            v2        <= v1;
            bkg_rgb   <= v2 ? data_In : 24'd0;
            bkg_valid <= v2;
        end
    end

`ifdef BKG_SCROLL_EN
    localparam logic [7:0] MAX_STEP_W = 8'(MAX_STEP);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  pend;
    logic [7:0]  offset_q;
    logic        tick_go;
    logic [7:0]  step;
    logic [7:0]  pend_base;
    logic [7:0]  amt_eff;
    logic [8:0]  pend_sum;
    logic [7:0]  pend_next;
    logic [8:0]  off_sum;
    logic [7:0]  off_next;

    always_comb begin
        tick_go   = frame_tick && (state == DRAIN);
        step      = 8'd0;
        if (tick_go)
            step = (pend > MAX_STEP_W) ? MAX_STEP_W : pend;
        pend_base = pend - step;
        amt_eff   = scroll_add ? scroll_amt : 8'd0;
        pend_sum  = {1'b0, pend_base} + {1'b0, amt_eff};
        pend_next = pend_sum[8] ? 8'hFF : pend_sum[7:0];
        off_sum   = {1'b0, offset_q} + {1'b0, step};
        off_next  = (off_sum >= DIM9) ? 8'(off_sum - DIM9) : off_sum[7:0];
    end

    // Offset only moves at frame boundaries so a frame never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            pend     <= 8'd0;
            offset_q <= 8'd0;
        end else begin
            pend <= pend_next;
            if (tick_go)
                offset_q <= off_next;
            unique case (state)
                IDLE: begin
                    if (scroll_add && (scroll_amt != 8'd0))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pend_next == 8'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign scroll_offset = offset_q;
`else
    logic unused_scroll;
    assign unused_scroll = ^{frame_tick, scroll_add, scroll_amt};
    assign scroll_offset = 8'd0;
`endif

endmodule

// File: tb/tb_bkg_scroll_reader.sv
// Directed bench for bkg_scroll_reader: address table, pipeline timing,
// reset behaviour and (with BKG_SCROLL_EN) scroll pacing.
module tb_bkg_scroll_reader;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_tick;
    logic        scroll_add;
    logic [7:0]  scroll_amt;
    logic [23:0] data_In;
    logic [14:0] read_address;
    logic [23:0] bkg_rgb;
    logic        bkg_valid;
    logic [7:0]  scroll_offset;

    int n_cmp = 0;
    int n_bad = 0;

    bkg_scroll_reader dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .frame_tick   (frame_tick),
        .scroll_add   (scroll_add),
        .scroll_amt   (scroll_amt),
        .data_In      (data_In),
        .read_address (read_address),
        .bkg_rgb      (bkg_rgb),
        .bkg_valid    (bkg_valid),
        .scroll_offset(scroll_offset)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [23:0] ram_fn(input logic [14:0] a);
        return 24'hA1B2C3 ^ {9'd0, a};
    endfunction

    // Synchronous-read RAM model
    always_ff @(posedge Clk)
        data_In <= ram_fn(read_address);

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vis;
        logic [14:0] addr;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic add(input logic [7:0] amt);
        scroll_add = 1'b1;
        scroll_amt = amt;
        step();
        scroll_add = 1'b0;
        scroll_amt = 8'd0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        vt[0]  = '{10'd0,    10'd0,    1'b1, 15'd0};
        vt[1]  = '{10'd639,  10'd479,  1'b1, 15'd19199};
        vt[2]  = '{10'd700,  10'd10,   1'b0, 15'd19199};
        vt[3]  = '{10'd4,    10'd4,    1'b1, 15'd161};
        vt[4]  = '{10'd3,    10'd3,    1'b1, 15'd0};
        vt[5]  = '{10'd100,  10'd800,  1'b0, 15'd0};
        vt[6]  = '{10'd639,  10'd0,    1'b1, 15'd159};
        vt[7]  = '{10'd0,    10'd479,  1'b1, 15'd19040};
        vt[8]  = '{10'd640,  10'd479,  1'b0, 15'd19040};
        vt[9]  = '{10'd320,  10'd240,  1'b1, 15'd9680};
        vt[10] = '{10'd7,    10'd13,   1'b1, 15'd481};
        vt[11] = '{10'd1023, 10'd1023, 1'b0, 15'd481};

        Reset_n    = 1'b1;
        frame_tick = 1'b0;
        scroll_add = 1'b0;
        scroll_amt = 8'd0;
        drive(10'd1023, 10'd1023);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_addr",  32'(read_address),  32'd0);
        chk("rst_rgb",   32'(bkg_rgb),       32'd0);
        chk("rst_valid", 32'(bkg_valid),     32'd0);
        chk("rst_off",   32'(scroll_offset), 32'd0);
        step();
        Reset_n = 1'b1;
        step();

        for (int c = 0; c < 14; c++) begin
            if (c < 12)
                drive(vt[c].x, vt[c].y);
            else
                drive(10'd1023, 10'd1023);
            step();
            if (c < 12)
                chk($sformatf("addr[%0d]", c), 32'(read_address),
                    32'(vt[c].addr));
            if (c >= 2) begin
                chk($sformatf("valid[%0d]", c - 2), 32'(bkg_valid),
                    32'(vt[c - 2].vis));
                chk($sformatf("rgb[%0d]", c - 2), 32'(bkg_rgb),
                    vt[c - 2].vis ? 32'(ram_fn(vt[c - 2].addr)) : 32'd0);
            end
        end
        drive(10'd1023, 10'd1023);
        step();

`ifdef BKG_SCROLL_EN
        do_reset();
        add(8'd40);
        chk("pend40", 32'(dut.pend), 32'd40);
        tick();
        chk("off31", 32'(scroll_offset), 32'd31);
        chk("pend9", 32'(dut.pend), 32'd9);
        tick();
        chk("off40", 32'(scroll_offset), 32'd40);
        chk("pend0", 32'(dut.pend), 32'd0);
        chk("idle", 32'(dut.state), 32'd0);
        tick();
        chk("off40_hold", 32'(scroll_offset), 32'd40);

        do_reset();
        add(8'd150);
        repeat (5) tick();
        chk("off150", 32'(scroll_offset), 32'd150);
        add(8'd31);
        chk("pend31", 32'(dut.pend), 32'd31);
        tick();
        chk("off_wrap21", 32'(scroll_offset), 32'd21);
        drive(10'd639, 10'd479);
        step();
        chk("addr_wrap", 32'(read_address), 32'd22559);
        drive(10'd0, 10'd0);
        step();
        chk("addr_off21", 32'(read_address), 32'd3360);
        drive(10'd1023, 10'd1023);

        do_reset();
        add(8'd250);
        chk("pend250", 32'(dut.pend), 32'd250);
        add(8'd20);
        chk("pend_sat", 32'(dut.pend), 32'd255);

        do_reset();
        add(8'd10);
        frame_tick = 1'b1;
        scroll_add = 1'b1;
        scroll_amt = 8'd5;
        step();
        frame_tick = 1'b0;
        scroll_add = 1'b0;
        scroll_amt = 8'd0;
        chk("coinc_off", 32'(scroll_offset), 32'd10);
        chk("coinc_pend", 32'(dut.pend), 32'd5);

        do_reset();
        add(8'd77);
        repeat (3) tick();
        chk("off77", 32'(scroll_offset), 32'd77);
        add(8'd100);
        chk("pend100", 32'(dut.pend), 32'd100);
`endif

        drive(10'd639, 10'd479);
        repeat (4) step();
        chk("pre_rst_valid", 32'(bkg_valid), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_addr",  32'(read_address),  32'd0);
        chk("mid_rst_rgb",   32'(bkg_rgb),       32'd0);
        chk("mid_rst_valid", 32'(bkg_valid),     32'd0);
        chk("mid_rst_off",   32'(scroll_offset), 32'd0);
`ifdef BKG_SCROLL_EN
        chk("mid_rst_pend",  32'(dut.pend),      32'd0);
`endif
        drive(10'd1023, 10'd1023);
        step();
        Reset_n = 1'b1;
        step();
        drive(10'd0, 10'd0);
        step();
        chk("refill_v1", 32'(bkg_valid), 32'd0);
        drive(10'd1023, 10'd1023);
        step();
        chk("refill_v2", 32'(bkg_valid), 32'd0);
        step();
        chk("refill_v3", 32'(bkg_valid), 32'd1);
        chk("refill_rgb", 32'(bkg_rgb), 32'hA1B2C3);
        step();
        chk("refill_v4", 32'(bkg_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bkg_scroll_reader.md
# bkg_scroll_reader

Read-side scan engine for the 160×160 24-bit background pixel RAM. It converts the VGA controller's DrawX/DrawY into RAM read addresses, scaling each background pixel to 4×4 screen pixels. It applies a vertical scroll offset that wraps modulo 160 rows and realigns the RAM's one-cycle read data with a valid flag for the colour mapper. Game logic requests scroll distance at any time; the block spreads that distance across frames, applying it only at frame boundaries so no frame tears.

## Interface

Parameters:
- `IMG_DIM`, 160: background width and height in pixels (square image).
- `SCALE_SH`, 2: log2 of the screen-pixel to image-pixel scale factor.
- `MAX_STEP`, 31: maximum rows applied per frame tick.

Ports:
- `Clk` in 1: pixel clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `DrawX` in 10: current screen column.
- `DrawY` in 10: current screen row.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `scroll_add` in 1: one-cycle pulse; adds `scroll_amt` to pending scroll.
- `scroll_amt` in 8: rows to add, sampled only when `scroll_add` is 1.
- `data_In` in 24: RAM read data, registered by the RAM one cycle after the address.
- `read_address` out 15: RAM read address.
- `bkg_rgb` out 24: background pixel colour.
- `bkg_valid` out 1: `bkg_rgb` corresponds to a visible pixel.
- `scroll_offset` out 8: current row offset, range 0..159.

## Operation

- Visible region: `DrawX < 640` and `DrawY < 480`.
- Column: `col = DrawX >> 2`, range 0..159.
- Row: `row = ((DrawY >> 2) + scroll_offset) mod 160`.
  - The sum is at most 119 + 159 = 278, so a single conditional subtract of 160 is sufficient.
- Address: `row*160 + col`, computed as `(row<<7) + (row<<5) + col`.
  - Maximum address is 25599; the result fits in 15 bits.
- Outside the visible region:
  - `read_address` holds its last value.
  - The pipelined valid flag is 0.
  - `bkg_rgb` is forced to 0.
- Pending scroll counter `pend`, 8 bits:
  - On `scroll_add`: `pend <= min(pend + scroll_amt, 255)`, saturating.
  - On `frame_tick`: `step = min(pend, MAX_STEP)`; `scroll_offset <= (scroll_offset + step) mod 160`; `pend <= pend - step`.
  - On simultaneous `frame_tick` and `scroll_add`: compute `step` from the old `pend`; then `pend <= min(pend - step + scroll_amt, 255)`.
- Scroll FSM, two states:
  - IDLE: `pend == 0`.
  - DRAIN: `pend != 0`.
  - IDLE→DRAIN on any `scroll_add` with nonzero `scroll_amt`.
  - DRAIN→IDLE on the `frame_tick` that reduces `pend` to 0.
  - `scroll_offset` changes only on `frame_tick` while in DRAIN.
- Reset, asynchronous with `Reset_n = 0`, including mid-frame or mid-drain. The following are cleared immediately:
  - `read_address = 0`, `bkg_rgb = 0`, `bkg_valid = 0`, `scroll_offset = 0`.
  - `pend = 0`, FSM = IDLE, all pipeline valid bits 0.

## Timing

- Cycle n: DrawX/DrawY presented.
- Cycle n+1: `read_address` is registered, along with the stage-1 valid flag.
- Cycle n+2: the RAM presents `data_In`; the stage-2 valid flag is registered.
- Cycle n+3: `bkg_rgb <= valid ? data_In : 0` and `bkg_valid` are registered.
- Total latency: 3 cycles from coordinates to `bkg_rgb`/`bkg_valid`. It is fixed, with no stalls.
- `scroll_offset` updates one cycle after `frame_tick`. Addresses issued from the following cycle use the new offset.
- Throughput: one pixel per cycle, continuous.

## Configuration

- `BKG_SCROLL_EN` defined:
  - Scroll counter, FSM and offset arithmetic are as described above.
- `BKG_SCROLL_EN` undefined:
  - `scroll_offset` is tied to 0; `pend` and the FSM are not built.
  - `frame_tick`, `scroll_add` and `scroll_amt` are ignored.
  - The address reduces to `(DrawY>>2)*160 + (DrawX>>2)`.
  - Pipeline latency is unchanged at 3 cycles.

## Test plan

- Reset, offset 0, DrawX=0, DrawY=0 → `read_address`=0 at n+1. DrawX=639, DrawY=479 → `read_address`=19199 at n+1.
- `data_In` returns 0xA1B2C3 for a visible pixel → `bkg_rgb`=0xA1B2C3 and `bkg_valid`=1 at n+3. DrawX=700 → `bkg_valid`=0 and `bkg_rgb`=0 at n+3.
- `scroll_add` with amt=40, then `frame_tick` → offset=31, pend=9. Second tick → offset=40, pend=0, FSM=IDLE. Third tick → offset stays 40.
- Offset=150, pend=31, `frame_tick` → offset=21 (wrap). Then DrawY=479, DrawX=639 → `read_address`=140*160+159=22559.
- pend=250, `scroll_add` amt=20 → pend=255 (saturate). `frame_tick` coincident with `scroll_add` amt=5 at pend=10 → offset+10, pend=5.
- `Reset_n` asserted mid-drain with pend=100 and offset=77 → all outputs and pend read 0 immediately. After release, the pipeline refills and `bkg_valid` first rises 3 cycles after the first visible coordinate.
